// File: rtl/ifid_stage_if.sv
// rtl/ifid_stage_if.sv - fetch/hazard inputs and ID-slot outputs of the IF/ID register
interface ifid_stage_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instr_in;
  logic [31:0]      pc_in;
  logic [31:0]      pcp4_in;
  logic             flush;
  logic             hold_in;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             mem_mem_read;
  logic [4:0]       mem_rd;
  logic [31:0]      instr_pype1;
  logic [31:0]      pc_pype1;
  logic [31:0]      pcp4_pype1;
  logic             valid_pype1;
  logic [4:0]       rs1_pype1;
  logic [4:0]       rs2_pype1;
  logic             stall_out;
  logic             bubble_out;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output instr_in, pc_in, pcp4_in, flush, hold_in,
           ex_reg_write, ex_mem_read, ex_rd, mem_mem_read, mem_rd,
    input  instr_pype1, pc_pype1, pcp4_pype1, valid_pype1,
           rs1_pype1, rs2_pype1, stall_out, bubble_out, stall_count
  );

  modport slave (
    input  instr_in, pc_in, pcp4_in, flush, hold_in,
           ex_reg_write, ex_mem_read, ex_rd, mem_mem_read, mem_rd,
    output instr_pype1, pc_pype1, pcp4_pype1, valid_pype1,
           rs1_pype1, rs2_pype1, stall_out, bubble_out, stall_count
  );
endinterface

// File: rtl/ifid_stage.sv
// rtl/ifid_stage.sv - IF/ID pipeline register with load-use and early-branch hazard stalls
module ifid_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0001_0060,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  ifid_stage_if.slave   bus
);

  typedef enum logic {RUN = 1'b0, STALL2 = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pcp4_q, pcp4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] rs1, rs2;
  logic       is_br, ex_match, mem_match;
  logic [1:0] need;
  logic       stall, bubble, hazard_stall;

  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];

  // x0 is hard-wired zero, so a write to it can never feed an operand
  always_comb begin
    is_br     = (instr_q[6:0] == 7'b1100011) || (instr_q[6:0] == 7'b1100111);
    ex_match  = (bus.ex_rd != 5'd0) && ((bus.ex_rd == rs1) || (bus.ex_rd == rs2));
    mem_match = (bus.mem_rd != 5'd0) && ((bus.mem_rd == rs1) || (bus.mem_rd == rs2));
    need      = 2'd0;
    if (valid_q) begin
      if (is_br && bus.ex_mem_read && ex_match)
        need = 2'd2;
      else if ((bus.ex_mem_read && ex_match) ||
               (is_br && bus.ex_reg_write && !bus.ex_mem_read && ex_match) ||
               (is_br && bus.mem_mem_read && mem_match))
        need = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.hold_in)           state_d = state_q;
    else if (bus.flush)        state_d = RUN;
    else if (state_q == STALL2) state_d = RUN;
    else if (need == 2'd2)     state_d = STALL2;
    else                       state_d = RUN;
  end

  always_comb begin
    stall        = 1'b0;
    bubble       = 1'b0;
    hazard_stall = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else if (bus.hold_in) begin
      stall = 1'b1;
    end else if (bus.flush) begin
      stall = 1'b0;
    end else if ((state_q == STALL2) || (need != 2'd0)) begin
      stall        = 1'b1;
      bubble       = 1'b1;
      hazard_stall = 1'b1;
    end
  end

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (bus.hold_in) begin
      cnt_d = cnt_q;
    end else if (bus.flush) begin
      instr_d = NOP_INSTR;
      pc_d    = bus.pc_in;
      pcp4_d  = bus.pcp4_in;
      valid_d = 1'b0;
    end else if (hazard_stall) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else begin
      instr_d = bus.instr_in;
      pc_d    = bus.pc_in;
      pcp4_d  = bus.pcp4_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      pcp4_q  <= RESET_PC + 32'd4;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.instr_pype1 = instr_q;
  assign bus.pc_pype1    = pc_q;
  assign bus.pcp4_pype1  = pcp4_q;
  assign bus.valid_pype1 = valid_q;
  assign bus.rs1_pype1   = rs1;
  assign bus.rs2_pype1   = rs2;
  assign bus.stall_out   = stall;
  assign bus.bubble_out  = bubble;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_ifid_stage.sv
// tb/tb_ifid_stage.sv - directed-vector bench for ifid_stage
module tb_ifid_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADD   = 32'h0020_81B3; // add x3,x1,x2
  localparam logic [31:0] BEQ   = 32'h0002_8063; // beq x5,x0,0
  localparam logic [31:0] ADD00 = 32'h0000_01B3; // add x3,x0,x0

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ifid_stage_if #(.CNT_W(16)) bus();

  ifid_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_haz();
    bus.flush        = 1'b0;
    bus.hold_in      = 1'b0;
    bus.ex_reg_write = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.ex_rd        = 5'd0;
    bus.mem_mem_read = 1'b0;
    bus.mem_rd       = 5'd0;
  endtask

  task automatic feed(input logic [31:0] ins, input logic [31:0] pc);
    bus.instr_in = ins;
    bus.pc_in    = pc;
    bus.pcp4_in  = pc + 32'd4;
  endtask

  task automatic ex_load(input logic [4:0] rd);
    bus.ex_reg_write = 1'b1;
    bus.ex_mem_read  = 1'b1;
    bus.ex_rd        = rd;
  endtask

  initial begin
    clr_haz();
    feed(32'hDEAD_BEEF, 32'h0000_0000);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    feed(NOP, 32'h0001_0060);
    #1;
    chk("rst_pc", bus.pc_pype1, 32'h0001_0060);
    chk("rst_pcp4", bus.pcp4_pype1, 32'h0001_0064);
    chk("rst_instr", bus.instr_pype1, NOP);
    chk("rst_valid", {31'd0, bus.valid_pype1}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_out}, 32'd0);
    chk("rst_bubble", {31'd0, bus.bubble_out}, 32'd0);
    chk("rst_cnt", {16'd0, bus.stall_count}, 32'd0);

    tick();
    chk("trk0_pc", bus.pc_pype1, 32'h0001_0060);
    chk("trk0_valid", {31'd0, bus.valid_pype1}, 32'd1);
    feed(NOP, 32'h0001_0064);
    tick();
    chk("trk1_pc", bus.pc_pype1, 32'h0001_0064);
    feed(ADD, 32'h0001_0068);
    tick();
    chk("trk2_pc", bus.pc_pype1, 32'h0001_0068);
    chk("trk2_instr", bus.instr_pype1, ADD);
    chk("rs1", {27'd0, bus.rs1_pype1}, 32'd1);
    chk("rs2", {27'd0, bus.rs2_pype1}, 32'd2);

    // load-use on add x3,x1,x2
    ex_load(5'd1);
    feed(NOP, 32'h0001_006C);
    #1;
    chk("lu_stall", {31'd0, bus.stall_out}, 32'd1);
    chk("lu_bubble", {31'd0, bus.bubble_out}, 32'd1);
    tick();
    clr_haz();
    #1;
    chk("lu_hold_instr", bus.instr_pype1, ADD);
    chk("lu_hold_pc", bus.pc_pype1, 32'h0001_0068);
    chk("lu_cnt", {16'd0, bus.stall_count}, 32'd1);
    chk("lu_release", {31'd0, bus.stall_out}, 32'd0);
    tick();
    chk("lu_adv_pc", bus.pc_pype1, 32'h0001_006C);

    // branch behind a load: two stall cycles
    feed(BEQ, 32'h0001_0070);
    tick();
    chk("br_instr", bus.instr_pype1, BEQ);
    ex_load(5'd5);
    feed(NOP, 32'h0001_0074);
    #1;
    chk("brl_stall1", {31'd0, bus.stall_out}, 32'd1);
    tick();
    clr_haz();
    #1;
    chk("brl_stall2", {31'd0, bus.stall_out}, 32'd1);
    chk("brl_bubble2", {31'd0, bus.bubble_out}, 32'd1);
    chk("brl_pc", bus.pc_pype1, 32'h0001_0070);
    tick();
    chk("brl_done", {31'd0, bus.stall_out}, 32'd0);
    chk("brl_cnt", {16'd0, bus.stall_count}, 32'd3);
    chk("brl_pc2", bus.pc_pype1, 32'h0001_0070);

    // branch behind an ALU write: one cycle
    bus.ex_reg_write = 1'b1;
    bus.ex_rd        = 5'd5;
    #1;
    chk("bra_stall", {31'd0, bus.stall_out}, 32'd1);
    tick();
    clr_haz();
    #1;
    chk("bra_done", {31'd0, bus.stall_out}, 32'd0);
    chk("bra_cnt", {16'd0, bus.stall_count}, 32'd4);

    // branch with a load in MEM: one cycle
    bus.mem_mem_read = 1'b1;
    bus.mem_rd       = 5'd5;
    #1;
    chk("brm_stall", {31'd0, bus.stall_out}, 32'd1);
    tick();
    clr_haz();
    #1;
    chk("brm_done", {31'd0, bus.stall_out}, 32'd0);
    chk("brm_cnt", {16'd0, bus.stall_count}, 32'd5);
    tick();
    chk("brm_adv_pc", bus.pc_pype1, 32'h0001_0074);

    // flush in the first cycle of a two-cycle stall
    feed(BEQ, 32'h0001_0080);
    tick();
    ex_load(5'd5);
    bus.flush = 1'b1;
    feed(32'h1111_1111, 32'h0001_0090);
    #1;
    chk("fl1_stall", {31'd0, bus.stall_out}, 32'd0);
    chk("fl1_bubble", {31'd0, bus.bubble_out}, 32'd0);
    tick();
    clr_haz();
    #1;
    chk("fl1_instr", bus.instr_pype1, NOP);
    chk("fl1_valid", {31'd0, bus.valid_pype1}, 32'd0);
    chk("fl1_pc", bus.pc_pype1, 32'h0001_0090);
    chk("fl1_stall_after", {31'd0, bus.stall_out}, 32'd0);
    chk("fl1_cnt", {16'd0, bus.stall_count}, 32'd5);

    // flush arriving in STALL2
    feed(BEQ, 32'h0001_00A0);
    tick();
    ex_load(5'd5);
    tick();
    clr_haz();
    bus.flush = 1'b1;
    feed(NOP, 32'h0001_00B0);
    #1;
    chk("fl2_stall", {31'd0, bus.stall_out}, 32'd0);
    tick();
    clr_haz();
    #1;
    chk("fl2_valid", {31'd0, bus.valid_pype1}, 32'd0);
    chk("fl2_pcp4", bus.pcp4_pype1, 32'h0001_00B4);
    chk("fl2_cnt", {16'd0, bus.stall_count}, 32'd6);

    // hold during a load-use hazard
    feed(ADD, 32'h0001_00C0);
    tick();
    bus.hold_in = 1'b1;
    ex_load(5'd1);
    feed(NOP, 32'h0001_00C4);
    #1;
    chk("hold_stall", {31'd0, bus.stall_out}, 32'd1);
    chk("hold_bubble", {31'd0, bus.bubble_out}, 32'd0);
    tick();
    tick();
    tick();
    chk("hold_pc", bus.pc_pype1, 32'h0001_00C0);
    chk("hold_cnt", {16'd0, bus.stall_count}, 32'd6);
    bus.hold_in = 1'b0;
    #1;
    chk("unhold_bubble", {31'd0, bus.bubble_out}, 32'd1);
    tick();
    chk("unhold_cnt", {16'd0, bus.stall_count}, 32'd7);

    // saturate the counter with a persistent load-use
    repeat (32'hFFFE - 7) tick();
    chk("sat_fffe", {16'd0, bus.stall_count}, 32'h0000_FFFE);
    tick();
    chk("sat_ffff", {16'd0, bus.stall_count}, 32'h0000_FFFF);
    tick();
    chk("sat_hold", {16'd0, bus.stall_count}, 32'h0000_FFFF);
    chk("sat_pc", bus.pc_pype1, 32'h0001_00C0);

    // a load to x0 never stalls
    clr_haz();
    feed(ADD00, 32'h0001_00D0);
    tick();
    ex_load(5'd0);
    feed(NOP, 32'h0001_00D4);
    #1;
    chk("x0_stall", {31'd0, bus.stall_out}, 32'd0);
    tick();
    chk("x0_adv_pc", bus.pc_pype1, 32'h0001_00D4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifid_stage.md
Name: ifid_stage

Overview:
- IF/ID pipeline register sitting directly downstream of the fetch stage.
- Latches the fetched instruction, PC and PC+4 every cycle.
- Detects load-use hazards and early-branch operand hazards on the instruction held in ID.
- On a hazard it asserts stall_out (drives fetch keep) and bubble_out (ID/EX inserts a NOP). On a redirect it squashes the ID slot.

Parameters:
- RESET_PC, 32'h0001_0060, PC value loaded into the register at reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- instr_in  in  32  instruction from fetch.
- pc_in  in  32  PC of instr_in.
- pcp4_in  in  32  PC+4 of instr_in.
- flush  in  1  any redirect (EX branch, early branch, CSR trap/return) this cycle.
- hold_in  in  1  global freeze from downstream (memory wait).
- ex_reg_write  in  1  instruction in EX writes a register.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  EX destination register.
- mem_mem_read  in  1  instruction in MEM is a load.
- mem_rd  in  5  MEM destination register.
- instr_pype1  out  32  ID instruction.
- pc_pype1  out  32  ID PC.
- pcp4_pype1  out  32  ID PC+4.
- valid_pype1  out  1  ID slot holds a real instruction.
- rs1_pype1  out  5  instr_pype1[19:15].
- rs2_pype1  out  5  instr_pype1[24:20].
- stall_out  out  1  to fetch keep: hold PC.
- bubble_out  out  1  to ID/EX: insert NOP this cycle.
- stall_count  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (rst=1 at edge):
  - instr=NOP_INSTR, pc=RESET_PC, pcp4=RESET_PC+4, valid=0, state=RUN, stall_count=0.
  - stall_out and bubble_out are 0 while the register is in its reset state.
  - Reset mid-stall returns to RUN immediately.
- Register operands:
  - rs1/rs2 decode from the register contents.
  - Hazards are evaluated only when valid_pype1=1.
  - Register x0 never causes a hazard.
- Hazard classification (combinational, from the ID register):
  - load_use: ex_mem_read and ex_rd matches rs1 or rs2. need=1.
  - br_alu: ID opcode is 1100011 or 1100111, ex_reg_write, not ex_mem_read, and ex_rd matches a source operand. need=1.
  - br_load_ex: ID is a branch/jalr and ex_mem_read with an ex_rd match. need=2.
  - br_load_mem: ID is a branch/jalr and mem_mem_read with an mem_rd match. need=1.
  - need is the maximum over all matching cases.
- FSM states: RUN, STALL2.
  - RUN, need=0: no stall.
  - RUN, need>=1: stall_out=1 and bubble_out=1; the ID register holds.
  - RUN, need=2: additionally go to STALL2.
  - STALL2: stall_out=1 and bubble_out=1 unconditionally for one cycle, then return to RUN, where hazards are re-evaluated.
- Precedence, highest first:
  - rst
  - hold_in: everything frozen, including the FSM and counter; stall_out=1, bubble_out=0.
  - flush: next ID = NOP_INSTR with valid=0, pc/pcp4 = pc_in/pcp4_in, state goes to RUN. stall_out=0 and bubble_out=0 that cycle, so fetch must redirect.
  - hazard stall.
  - normal load: instr_in/pc_in/pcp4_in, valid=1.
- Flush arriving in STALL2 aborts the stall.
- Flush and a hazard in the same cycle: flush wins, and the hazard is not counted.
- stall_count:
  - Increments by 1 each cycle stall_out=1 caused by a hazard; hold_in cycles do not count.
  - Saturates at all-ones and never wraps.
- Latency: an instruction presented at edge N appears on instr_pype1 after edge N; registered, 1 cycle.

Test Plan:
- Reset then release; feed pc_in 0x10060/0x10064/0x10068 -> after reset pc_pype1=0x10060, valid=0, stall_out=0; following edges track pc_in with valid=1.
- ID holds add x3,x1,x2 while EX is a load with ex_rd=1 -> stall_out=1 and bubble_out=1 for exactly 1 cycle, ID unchanged, stall_count=1.
- ID holds beq x5,x0, EX is a load with ex_rd=5 -> 2 stall cycles (RUN→STALL2→RUN), stall_count=2; the same with a non-load EX write -> 1 cycle.
- Flush asserted in the first cycle of a 2-cycle stall -> next cycle instr_pype1=0x00000013, valid=0, state RUN, stall_out=0.
- hold_in=1 for 3 cycles during a load-use hazard -> outputs frozen, bubble_out=0, stall_count unchanged; after release, one hazard stall is counted.
- Preload stall_count to 0xFFFE via repeated hazards -> saturates at 0xFFFF; ex_rd=0 hazard pattern -> no stall.
